// File: rtl/rtc_bus_sequencer.sv
// ============================================================================
//  Module      : rtc_bus_sequencer
//  Description : Bus-cycle sequencer for a multiplexed address/data RTC
//                interface. Generates cs_n/ad_n/rd_n/wr_n strobes and the
//                bus drive/enable directly from a phase-timed state machine.
//                Each transaction is a read or a write, optionally preceded
//                by an address phase. Uses a start/busy/done handshake and
//                captures read data on the last read-strobe cycle.
//
//  Optional    : RTC_SEQ_READBACK_EN - a write is followed by a verify read
//                (GAP, V_SETUP, V_STROBE, V_HOLD). The read-back value is
//                compared with the written data and reported on verify_err.
//
//  Ports       : clk, reset        clock, asynchronous active-high reset
//                start             request, sampled only in IDLE
//                op                1 = read data phase, 0 = write data phase
//                addr_en           1 = address phase precedes data phase
//                addr, wr_data     register address / write data
//                bus_in            bus value during reads
//                busy, done        handshake (done = one-cycle pulse)
//                rd_data, rd_valid captured read data / pulse with done
//                cs_n, ad_n, rd_n, wr_n   RTC bus strobes
//                bus_out, bus_oe   driven bus value and its tristate enable
//                verify_err        (readback builds only) verify mismatch
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_sequencer #(
    parameter int DATA_W   = 8,
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2,
    parameter int T_GAP    = 3,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic              addr_en,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] bus_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              cs_n,
    output logic              ad_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe
`ifdef RTC_SEQ_READBACK_EN
    ,
    output logic              verify_err
`endif
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_A_SETUP  = 4'd1,
        S_A_STROBE = 4'd2,
        S_A_HOLD   = 4'd3,
        S_GAP      = 4'd4,
        S_D_SETUP  = 4'd5,
        S_D_STROBE = 4'd6,
        S_D_HOLD   = 4'd7,
        S_DONE     = 4'd8
`ifdef RTC_SEQ_READBACK_EN
        ,
        S_V_SETUP  = 4'd9,
        S_V_STROBE = 4'd10,
        S_V_HOLD   = 4'd11
`endif
    } state_t;

    // Counter reload values: a state lasting T cycles counts T-1 down to 0.
    localparam logic [CNT_W-1:0] c_setup_ld  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] c_strobe_ld = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] c_hold_ld   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] c_gap_ld    = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_op;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wr_data;
`ifdef RTC_SEQ_READBACK_EN
    logic                r_verify;      // second pass through GAP leads to V_*
    logic                r_mismatch;
`endif

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_cnt_zero;
    logic                w_accept;
    logic                w_op_eff;
    logic [DATA_W-1:0]   w_addr_eff;
    logic [DATA_W-1:0]   w_wd_eff;
    logic                w_in_a;
    logic                w_in_d;
    logic                w_in_v;
    logic                w_drive_wd;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_accept   = (r_state == S_IDLE) && start;

    // Outputs are registered from the next state, so the request fields must
    // be taken straight from the inputs on the accepting edge.
    assign w_op_eff   = w_accept ? op      : r_op;
    assign w_addr_eff = w_accept ? addr    : r_addr;
    assign w_wd_eff   = w_accept ? wr_data : r_wr_data;

    // ------------------------------------------------------------------
    // Next-state and phase counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - c_one;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (start) begin
                    w_state_nxt = addr_en ? S_A_SETUP : S_D_SETUP;
                    w_cnt_nxt   = c_setup_ld;
                end
            end
            S_A_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_A_STROBE;
                    w_cnt_nxt   = c_strobe_ld;
                end
            end
            S_A_STROBE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_A_HOLD;
                    w_cnt_nxt   = c_hold_ld;
                end
            end
            S_A_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = c_gap_ld;
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
`ifdef RTC_SEQ_READBACK_EN
                    w_state_nxt = r_verify ? S_V_SETUP : S_D_SETUP;
`else
                    w_state_nxt = S_D_SETUP;
`endif
                    w_cnt_nxt   = c_setup_ld;
                end
            end
            S_D_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_D_STROBE;
                    w_cnt_nxt   = c_strobe_ld;
                end
            end
            S_D_STROBE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_D_HOLD;
                    w_cnt_nxt   = c_hold_ld;
                end
            end
            S_D_HOLD: begin
                if (w_cnt_zero) begin
`ifdef RTC_SEQ_READBACK_EN
                    if (!r_op) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = c_gap_ld;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef RTC_SEQ_READBACK_EN
            S_V_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_V_STROBE;
                    w_cnt_nxt   = c_strobe_ld;
                end
            end
            S_V_STROBE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_V_HOLD;
                    w_cnt_nxt   = c_hold_ld;
                end
            end
            S_V_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = r_cnt;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase-group decode of the next state
    // ------------------------------------------------------------------
    always_comb begin
        w_in_a = (w_state_nxt == S_A_SETUP) || (w_state_nxt == S_A_STROBE) ||
                 (w_state_nxt == S_A_HOLD);
        w_in_d = (w_state_nxt == S_D_SETUP) || (w_state_nxt == S_D_STROBE) ||
                 (w_state_nxt == S_D_HOLD);
`ifdef RTC_SEQ_READBACK_EN
        w_in_v = (w_state_nxt == S_V_SETUP) || (w_state_nxt == S_V_STROBE) ||
                 (w_state_nxt == S_V_HOLD);
`else
        w_in_v = 1'b0;
`endif
        w_drive_wd = w_in_d && !w_op_eff;
    end

    // ------------------------------------------------------------------
    // State, latched request and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            cs_n       <= 1'b1;
            ad_n       <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            bus_oe     <= 1'b0;
            bus_out    <= '0;
`ifdef RTC_SEQ_READBACK_EN
            r_verify   <= 1'b0;
            r_mismatch <= 1'b0;
            verify_err <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;

            if (w_accept) begin
                r_op      <= op;
                r_addr    <= addr;
                r_wr_data <= wr_data;
            end

            busy     <= (w_state_nxt != S_IDLE);
            done     <= (w_state_nxt == S_DONE);
            rd_valid <= (w_state_nxt == S_DONE) && w_op_eff;
            cs_n     <= !(w_in_a || w_in_d || w_in_v || (w_state_nxt == S_GAP));
            ad_n     <= !w_in_a;
            wr_n     <= !((w_state_nxt == S_A_STROBE) ||
                          ((w_state_nxt == S_D_STROBE) && !w_op_eff));
`ifdef RTC_SEQ_READBACK_EN
            rd_n     <= !(((w_state_nxt == S_D_STROBE) && w_op_eff) ||
                          (w_state_nxt == S_V_STROBE));
`else
            rd_n     <= !((w_state_nxt == S_D_STROBE) && w_op_eff);
`endif
            bus_oe   <= w_in_a || w_drive_wd;
            if (w_in_a) begin
                bus_out <= w_addr_eff;
            end else if (w_drive_wd) begin
                bus_out <= w_wd_eff;
            end else begin
                bus_out <= '0;
            end

            // Sample the bus at the end of the read strobe.
            if ((r_state == S_D_STROBE) && w_cnt_zero && r_op) begin
                rd_data <= bus_in;
            end

`ifdef RTC_SEQ_READBACK_EN
            if (w_accept) begin
                r_verify   <= 1'b0;
                r_mismatch <= 1'b0;
                verify_err <= 1'b0;
            end else begin
                if ((r_state == S_D_HOLD) && (w_state_nxt == S_GAP)) begin
                    r_verify <= 1'b1;
                end
                if ((r_state == S_V_STROBE) && w_cnt_zero) begin
                    r_mismatch <= (bus_in != r_wr_data);
                end
                if (w_state_nxt == S_DONE) begin
                    verify_err <= r_mismatch;
                end
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
// ============================================================================
//  Module      : tb_rtc_bus_sequencer
//  Description : Self-checking bench for rtc_bus_sequencer. A segment-based
//                reference model lists the expected strobe/bus vector for
//                every busy cycle of a transaction; the bench compares the
//                DUT against it cycle by cycle. A second instance with all
//                phase durations set to 1 covers the minimum-timing case.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rtc_bus_sequencer;

    localparam int DW = 8;
    localparam int TS = 2;
    localparam int TT = 4;
    localparam int TH = 2;
    localparam int TG = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic          op;
    logic          addr_en;
    logic [DW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] bus_in;

    logic          busy, done, rd_valid, cs_n, ad_n, rd_n, wr_n, bus_oe;
    logic [DW-1:0] rd_data, bus_out;
    logic          b1_busy, b1_done, b1_rd_valid, b1_cs_n, b1_ad_n, b1_rd_n, b1_wr_n, b1_bus_oe;
    logic [DW-1:0] b1_rd_data, b1_bus_out;
`ifdef RTC_SEQ_READBACK_EN
    logic          verify_err;
    logic          b1_verify_err;
`endif

    rtc_bus_sequencer #(
        .DATA_W(DW), .T_SETUP(TS), .T_STROBE(TT), .T_HOLD(TH), .T_GAP(TG), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr_en(addr_en),
        .addr(addr), .wr_data(wr_data), .bus_in(bus_in),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n),
        .bus_out(bus_out), .bus_oe(bus_oe)
`ifdef RTC_SEQ_READBACK_EN
        , .verify_err(verify_err)
`endif
    );

    rtc_bus_sequencer #(
        .DATA_W(DW), .T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_GAP(1), .CNT_W(4)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr_en(addr_en),
        .addr(addr), .wr_data(wr_data), .bus_in(bus_in),
        .busy(b1_busy), .done(b1_done), .rd_data(b1_rd_data), .rd_valid(b1_rd_valid),
        .cs_n(b1_cs_n), .ad_n(b1_ad_n), .rd_n(b1_rd_n), .wr_n(b1_wr_n),
        .bus_out(b1_bus_out), .bus_oe(b1_bus_oe)
`ifdef RTC_SEQ_READBACK_EN
        , .verify_err(b1_verify_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, done, rd_valid, cs_n, ad_n, rd_n, wr_n, bus_oe, bus_out}
    typedef struct packed {
        logic          busy;
        logic          done;
        logic          rd_valid;
        logic          cs_n;
        logic          ad_n;
        logic          rd_n;
        logic          wr_n;
        logic          bus_oe;
        logic [DW-1:0] bus_out;
    } vec_t;

    int            checks;
    int            failures;
    vec_t          exp_q[$];
    int            rd_idx;
    int            v_idx;
    logic [DW-1:0] exp_rd_data;
    logic          exp_verr;

    function automatic vec_t mk(input logic b, input logic d, input logic rv, input logic cs,
                                input logic ad, input logic rd, input logic wr, input logic oe,
                                input logic [DW-1:0] o);
        vec_t v;
        v = {b, d, rv, cs, ad, rd, wr, oe, o};
        return v;
    endfunction

    function automatic vec_t act_vec();
        vec_t v;
        v = {busy, done, rd_valid, cs_n, ad_n, rd_n, wr_n, bus_oe, bus_out};
        return v;
    endfunction

    function automatic logic act_verr();
`ifdef RTC_SEQ_READBACK_EN
        return verify_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_seg(input int n, input vec_t v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Reference: a transaction is a list of phases, each a constant output
    // vector held for its duration.
    task automatic build_trace(input logic o, input logic ae,
                               input logic [DW-1:0] a, input logic [DW-1:0] w);
        vec_t          gap;
        logic [DW-1:0] dv;
        exp_q.delete();
        rd_idx = -1;
        v_idx  = -1;
        gap    = mk(1, 0, 0, 0, 1, 1, 1, 0, '0);
        dv     = o ? '0 : w;
        if (ae) begin
            push_seg(TS, mk(1, 0, 0, 0, 0, 1, 1, 1, a));
            push_seg(TT, mk(1, 0, 0, 0, 0, 1, 0, 1, a));
            push_seg(TH, mk(1, 0, 0, 0, 0, 1, 1, 1, a));
            push_seg(TG, gap);
        end
        push_seg(TS, mk(1, 0, 0, 0, 1, 1, 1, !o, dv));
        rd_idx = exp_q.size() + TT - 1;
        push_seg(TT, mk(1, 0, 0, 0, 1, !o, o, !o, dv));
        push_seg(TH, mk(1, 0, 0, 0, 1, 1, 1, !o, dv));
`ifdef RTC_SEQ_READBACK_EN
        if (!o) begin
            push_seg(TG, gap);
            push_seg(TS, mk(1, 0, 0, 0, 1, 1, 1, 0, '0));
            v_idx = exp_q.size() + TT - 1;
            push_seg(TT, mk(1, 0, 0, 0, 1, 0, 1, 0, '0));
            push_seg(TH, mk(1, 0, 0, 0, 1, 1, 1, 0, '0));
        end
`endif
        push_seg(1, mk(1, 1, o, 1, 1, 1, 1, 0, '0));
    endtask

    // Starts at a falling edge with the DUT idle and ends at the falling edge
    // of the single IDLE cycle that follows DONE.
    // mode 0: inputs quiet; 1: random start/request noise; 2: start held high.
    task automatic run_txn(input logic o, input logic ae, input logic [DW-1:0] a,
                           input logic [DW-1:0] w, input int mode, input int fixed_bus,
                           input string name);
        logic [DW-1:0] b;
        build_trace(o, ae, a, w);
        exp_verr = 1'b0;
        start    = 1'b1;
        op       = o;
        addr_en  = ae;
        addr     = a;
        wr_data  = w;
        @(posedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_q[k]) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%h expected=%h", name, k, act_vec(), exp_q[k]);
            end
            if (k == exp_q.size() - 1) begin
                checks++;
                if (rd_data !== exp_rd_data) begin
                    failures++;
                    $display("FAIL %s rd_data got=%h expected=%h", name, rd_data, exp_rd_data);
                end
                checks++;
                if (act_verr() !== exp_verr) begin
                    failures++;
                    $display("FAIL %s verify_err got=%b expected=%b", name, act_verr(), exp_verr);
                end
            end
            if (fixed_bus >= 0) b = DW'(fixed_bus);
            else b = ($urandom_range(0, 1) == 1) ? w : DW'($urandom);
            bus_in = b;
            if (k == rd_idx && o) exp_rd_data = b;
            if (k == v_idx) exp_verr = (b != w);
            if (mode != 0) begin
                start   = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                op      = 1'($urandom);
                addr_en = 1'($urandom);
                addr    = DW'($urandom);
                wr_data = DW'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (act_vec() !== mk(0, 0, 0, 1, 1, 1, 1, 0, '0)) begin
            failures++;
            $display("FAIL %s idle_after got=%h expected=%h", name, act_vec(),
                     mk(0, 0, 0, 1, 1, 1, 1, 0, '0));
        end
        checks++;
        if (rd_data !== exp_rd_data || act_verr() !== exp_verr) begin
            failures++;
            $display("FAIL %s hold_after rd_data=%h/%h verify_err=%b/%b", name,
                     rd_data, exp_rd_data, act_verr(), exp_verr);
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        exp_rd_data = '0;
        exp_verr    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (act_vec() !== mk(0, 0, 0, 1, 1, 1, 1, 0, '0) || rd_data !== '0 || act_verr() !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got=%h rd_data=%h verify_err=%b expected=%h 00 0",
                     act_vec(), rd_data, act_verr(), mk(0, 0, 0, 1, 1, 1, 1, 0, '0));
        end
        reset       = 1'b0;
        exp_rd_data = '0;
        exp_verr    = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || b1_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start busy=%b b1_busy=%b expected 0 0", busy, b1_busy);
        end
    endtask

    task automatic test_min_timing();
        for (int t = 0; t < 2; t++) begin
            logic o;
            int n_busy, n_cs, n_ad, n_wr, n_rd, n_done, run_wr, run_rd, max_run;
            int e_busy, e_wr, e_rd;
            o = (t == 1);
            n_busy = 0; n_cs = 0; n_ad = 0; n_wr = 0; n_rd = 0; n_done = 0;
            run_wr = 0; run_rd = 0; max_run = 0;
            start = 1'b1; op = o; addr_en = 1'b1;
            addr = DW'($urandom); wr_data = DW'($urandom);
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (b1_busy)  n_busy++;
                if (!b1_cs_n) n_cs++;
                if (!b1_ad_n) n_ad++;
                if (b1_done)  n_done++;
                if (!b1_wr_n) begin n_wr++; run_wr++; end else run_wr = 0;
                if (!b1_rd_n) begin n_rd++; run_rd++; end else run_rd = 0;
                if (run_wr > max_run) max_run = run_wr;
                if (run_rd > max_run) max_run = run_rd;
                @(negedge clk);
            end
            e_busy = 8;
            e_wr   = o ? 1 : 2;
            e_rd   = o ? 1 : 0;
`ifdef RTC_SEQ_READBACK_EN
            if (!o) begin
                e_busy = 12;
                e_rd   = 1;
            end
`endif
            checks++;
            if (n_busy != e_busy || n_done != 1) begin
                failures++;
                $display("FAIL min_busy op=%b busy=%0d done=%0d expected %0d 1", o, n_busy, n_done, e_busy);
            end
            checks++;
            if (n_cs != e_busy - 1 || n_ad != 3) begin
                failures++;
                $display("FAIL min_cs_ad op=%b cs_low=%0d ad_low=%0d expected %0d 3", o, n_cs, n_ad, e_busy - 1);
            end
            checks++;
            if (n_wr != e_wr || n_rd != e_rd || max_run != 1) begin
                failures++;
                $display("FAIL min_strobes op=%b wr=%0d rd=%0d longest=%0d expected %0d %0d 1",
                         o, n_wr, n_rd, max_run, e_wr, e_rd);
            end
        end
        // The main instance also ran; return both to a known state.
        do_reset();
    endtask

    task automatic test_write_addr();
        run_txn(1'b0, 1'b1, 8'h21, 8'h45, 0, -1, "write_addr");
    endtask

    task automatic test_read_noaddr();
        run_txn(1'b1, 1'b0, 8'h10, 8'h99, 0, 8'h37, "read_noaddr");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_txn(1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), 1, -1, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            run_txn(1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), 2, -1, "back_to_back");
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w;
        w = DW'($urandom);
        start = 1'b1; op = 1'b0; addr_en = 1'b0; addr = '0; wr_data = w;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (TS) @(negedge clk);
        checks++;
        if (wr_n !== 1'b0 || bus_out !== w) begin
            failures++;
            $display("FAIL mid_in_strobe wr_n=%b bus_out=%h expected 0 %h", wr_n, bus_out, w);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (act_vec() !== mk(0, 0, 0, 1, 1, 1, 1, 0, '0)) begin
            failures++;
            $display("FAIL mid_reset_async got=%h expected=%h", act_vec(), mk(0, 0, 0, 1, 1, 1, 1, 0, '0));
        end
        exp_rd_data = '0;
        exp_verr    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_done cycle=%0d done=%b busy=%b expected 0 0", k, done, busy);
            end
        end
        run_txn(1'b0, 1'b0, DW'($urandom), DW'($urandom), 0, -1, "after_reset");
    endtask

    task automatic test_readback();
        run_txn(1'b0, 1'b1, 8'h03, 8'h5A, 0, 8'h5A, "readback_match");
        run_txn(1'b0, 1'b1, 8'h03, 8'h5A, 0, 8'h5B, "readback_mismatch");
        run_txn(1'b1, 1'b0, 8'h04, 8'h00, 0, 8'hC3, "read_after_verify");
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; op = 1'b0; addr_en = 1'b0;
        addr = '0; wr_data = '0; bus_in = '0;
        exp_rd_data = '0; exp_verr = 1'b0;
        test_reset();
        test_min_timing();
        test_write_addr();
        test_read_noaddr();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_readback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
